matmul_sequencer: RTL

- Control sequencer that owns one matmul calc unit.
- Accepts a job request (dims, mode, scratchpad select) from the control-register block and fetches A/B rows and C-bias words from operand memory.
- Drives the calc unit's start/load window, forwards its result writes to the selected scratchpad, and collects overflow flags.
- Enforces a completion timeout and reports busy/done/status to the control block.

---
 rtl/matmul_sequencer_if.sv | 58 +++++
 rtl/matmul_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: job config, operand-memory read, calc-unit and scratchpad signals.
// master is the sequencer side, slave is the surrounding system.
interface matmul_sequencer_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                  cfg_start_i;
    logic                  cfg_mode_i;
    logic [1:0]            cfg_n_dim_i;
    logic [1:0]            cfg_k_dim_i;
    logic [1:0]            cfg_m_dim_i;
    logic [1:0]            cfg_sp_sel_i;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [BUS_WIDTH-1:0]  rd_data_a_i;
    logic [BUS_WIDTH-1:0]  rd_data_b_i;
    logic [BUS_WIDTH-1:0]  rd_data_c_i;
    logic                  calc_start_o;
    logic                  calc_mode_o;
    logic [1:0]            calc_n_dim_o;
    logic [1:0]            calc_k_dim_o;
    logic [1:0]            calc_m_dim_o;
    logic [BUS_WIDTH-1:0]  calc_data_a_o;
    logic [BUS_WIDTH-1:0]  calc_data_b_o;
    logic [BUS_WIDTH-1:0]  calc_data_c_o;
    logic                  calc_we_i;
    logic [ADDR_WIDTH-1:0] calc_addr_i;
    logic [BUS_WIDTH-1:0]  calc_data_i;
    logic [BUS_WIDTH-1:0]  calc_flags_i;
    logic                  calc_finish_i;
    logic                  sp_we_o;
    logic [ADDR_WIDTH-1:0] sp_addr_o;
    logic [BUS_WIDTH-1:0]  sp_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic [BUS_WIDTH-1:0]  flags_o;
    logic                  timeout_o;

    modport master (
        input  cfg_start_i, cfg_mode_i, cfg_n_dim_i, cfg_k_dim_i, cfg_m_dim_i, cfg_sp_sel_i,
        input  rd_data_a_i, rd_data_b_i, rd_data_c_i,
        input  calc_we_i, calc_addr_i, calc_data_i, calc_flags_i, calc_finish_i,
        output rd_en_o, rd_addr_o,
        output calc_start_o, calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o,
        output calc_data_a_o, calc_data_b_o, calc_data_c_o,
        output sp_we_o, sp_addr_o, sp_data_o, busy_o, done_o, flags_o, timeout_o
    );

    modport slave (
        output cfg_start_i, cfg_mode_i, cfg_n_dim_i, cfg_k_dim_i, cfg_m_dim_i, cfg_sp_sel_i,
        output rd_data_a_i, rd_data_b_i, rd_data_c_i,
        output calc_we_i, calc_addr_i, calc_data_i, calc_flags_i, calc_finish_i,
        input  rd_en_o, rd_addr_o,
        input  calc_start_o, calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o,
        input  calc_data_a_o, calc_data_b_o, calc_data_c_o,
        input  sp_we_o, sp_addr_o, sp_data_o, busy_o, done_o, flags_o, timeout_o
    );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: fetches operand rows into a matmul calc unit, forwards its result
// writes to a scratchpad, and reports done/overflow/timeout status.
module matmul_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk_i,
    input logic                rst_i,
    matmul_sequencer_if.master bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int RW = MAX_DIM > 1 ? $clog2(MAX_DIM) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD_TAIL, COMPUTE, DONE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         r_q, r_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [1:0]            n_q, n_d, k_q, k_d, m_q, m_d, sp_sel_q, sp_sel_d;
    logic [BUS_WIDTH-1:0]  flags_q, flags_d;
    logic                  timeout_q, timeout_d;
    logic                  calc_start_q, calc_start_d;
    logic                  done_q, done_d;
    logic                  sp_we_q, sp_we_d;
    logic [ADDR_WIDTH-1:0] sp_addr_q, sp_addr_d;
    logic [BUS_WIDTH-1:0]  sp_data_q, sp_data_d;
    logic                  compute;
    logic                  unused_addr;

    assign unused_addr = ^bus.calc_addr_i[ADDR_WIDTH-1:7];

    always_comb begin
        compute      = state_q == COMPUTE;
        calc_start_d = state_q == FETCH;
        done_d       = state_q == DONE;
        sp_we_d      = compute & bus.calc_we_i;
        sp_addr_d    = compute ? {{(ADDR_WIDTH-9){1'b0}}, sp_sel_q, bus.calc_addr_i[6:0]} : sp_addr_q;
        sp_data_d    = compute ? bus.calc_data_i : sp_data_q;
        state_d      = state_q;
        r_d          = r_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        n_d          = n_q;
        k_d          = k_q;
        m_d          = m_q;
        sp_sel_d     = sp_sel_q;
        flags_d      = flags_q;
        timeout_d    = timeout_q;
        case (state_q)
            IDLE: if (bus.cfg_start_i) begin
                mode_d    = bus.cfg_mode_i;
                n_d       = bus.cfg_n_dim_i;
                k_d       = bus.cfg_k_dim_i;
                m_d       = bus.cfg_m_dim_i;
                sp_sel_d  = bus.cfg_sp_sel_i;
                flags_d   = '0;
                timeout_d = 1'b0;
                r_d       = '0;
                cnt_d     = '0;
                state_d   = FETCH;
            end
            FETCH: begin
                r_d = r_q + 1'b1;
                if (r_q == RW'(MAX_DIM - 1)) begin
                    r_d     = '0;
                    state_d = LOAD_TAIL;
                end
            end
            LOAD_TAIL: state_d = COMPUTE;
            COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                // a finish arriving on the last allowed cycle still counts as success
                if (bus.calc_finish_i) begin
                    flags_d = flags_q | bus.calc_flags_i;
                    state_d = DONE;
                end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            r_q          <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            m_q          <= '0;
            sp_sel_q     <= '0;
            flags_q      <= '0;
            timeout_q    <= 1'b0;
            calc_start_q <= 1'b0;
            done_q       <= 1'b0;
            sp_we_q      <= 1'b0;
            sp_addr_q    <= '0;
            sp_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            n_q          <= n_d;
            k_q          <= k_d;
            m_q          <= m_d;
            sp_sel_q     <= sp_sel_d;
            flags_q      <= flags_d;
            timeout_q    <= timeout_d;
            calc_start_q <= calc_start_d;
            done_q       <= done_d;
            sp_we_q      <= sp_we_d;
            sp_addr_q    <= sp_addr_d;
            sp_data_q    <= sp_data_d;
        end
    end

    assign bus.rd_en_o       = state_q == FETCH;
    assign bus.rd_addr_o     = {{(ADDR_WIDTH-RW){1'b0}}, r_q};
    assign bus.calc_start_o  = calc_start_q;
    assign bus.calc_mode_o   = mode_q;
    assign bus.calc_n_dim_o  = n_q;
    assign bus.calc_k_dim_o  = k_q;
    assign bus.calc_m_dim_o  = m_q;
    assign bus.calc_data_a_o = bus.rd_data_a_i;
    assign bus.calc_data_b_o = bus.rd_data_b_i;
    assign bus.calc_data_c_o = bus.rd_data_c_i;
    assign bus.sp_we_o       = sp_we_q;
    assign bus.sp_addr_o     = sp_addr_q;
    assign bus.sp_data_o     = sp_data_q;
    assign bus.busy_o        = state_q != IDLE;
    assign bus.done_o        = done_q;
    assign bus.flags_o       = flags_q;
    assign bus.timeout_o     = timeout_q;
endmodule
